// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: shared definitions for the DP job sequencer.
// Holds the 3-bit FSM state encodings and the default DP array geometry.
package dp_sched_pkg;

  // Default DP array geometry shared with the systolic wrapper.
  localparam int DP_N        = 64;
  localparam int DP_LOG_N    = 6;
  localparam int DP_BP_W     = 2;
  localparam int DP_LEN_W    = 12;
  localparam int DP_PIPE_LAT = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_S   = 3'd1,
    ST_STREAM_T = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_t;

  // True in the states where the DP array is consuming or draining the reference.
  function automatic logic is_dp_active(input sched_state_t st);
    return (st == ST_STREAM_T) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/dp_bank_credit.sv
// dp_bank_credit: two-bank credit counter for the DP result banks.
// A credit is consumed on each bank swap and returned on each falling edge
// of the traceback-busy flag; the count saturates at 0 and 2.
module dp_bank_credit (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       i_consume,
  input  logic       i_tb_busy,
  output logic [1:0] o_credits
);

  logic       r_tb_busy_d;
  logic       w_release;
  logic [1:0] r_credits;

  assign w_release = r_tb_busy_d & ~i_tb_busy;
  assign o_credits = r_credits;

  // Registered copy of tb_busy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_tb_busy_d <= 1'b0;
    end else begin
      r_tb_busy_d <= i_tb_busy;
    end
  end

  // Saturating credit count; a simultaneous consume and release cancel out.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_credits <= 2'd2;
    end else begin
      case ({i_consume, w_release})
        2'b10: begin
          if (r_credits != 2'd0) r_credits <= r_credits - 2'd1;
          else                   r_credits <= r_credits;
        end
        2'b01: begin
          if (r_credits < 2'd2) r_credits <= r_credits + 2'd1;
          else                  r_credits <= r_credits;
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

endmodule

// File: rtl/dp_sched.sv
// dp_sched: job sequencer in front of the two-bank DP systolic wrapper.
// Loads query bases, streams reference bases under busy back-pressure,
// drains the array and issues the new_seq bank swap, gated by bank credits.
// Build macro DP_SCHED_PERF_EN enables the perf_jobs / perf_stalls counters.
module dp_sched
  import dp_sched_pkg::*;
#(
  parameter int N        = DP_N,
  parameter int LOG_N    = DP_LOG_N,
  parameter int BP_W     = DP_BP_W,
  parameter int LEN_W    = DP_LEN_W,
  parameter int PIPE_LAT = DP_PIPE_LAT
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LOG_N:0]   job_s_len,
  input  logic [LEN_W-1:0] job_t_len,
  input  logic             src_s_valid,
  input  logic [BP_W-1:0]  src_s_data,
  output logic             src_s_ready,
  input  logic             src_t_valid,
  input  logic [BP_W-1:0]  src_t_data,
  output logic             src_t_ready,
  output logic [BP_W-1:0]  S,
  output logic [BP_W-1:0]  T,
  output logic             s_update,
  output logic             valid,
  output logic             new_seq,
  output logic             ack,
  output logic [LOG_N-1:0] PE_end,
  input  logic             busy,
  input  logic             tb_busy,
  output logic             done,
  output logic [1:0]       credits,
  output logic [15:0]      perf_jobs,
  output logic [15:0]      perf_stalls
);

  sched_state_t     r_state;
  sched_state_t     w_next_state;
  logic [LOG_N:0]   w_s_len;
  logic [LOG_N:0]   r_s_len;
  logic [LOG_N:0]   r_s_cnt;
  logic [LEN_W-1:0] r_t_cnt;
  logic [LEN_W-1:0] r_drain_cnt;
  logic [LEN_W-1:0] w_drain_load;
  logic             w_accept;
  logic             w_s_beat;
  logic             w_t_beat;
  logic             w_zero_job;
  logic             w_drain_en;
  logic             w_credit_ok;
  logic             r_new_seq;

  // Query lengths beyond the array size are clamped so PE_end stays in range.
  assign w_s_len      = (job_s_len > (LOG_N+1)'(N)) ? (LOG_N+1)'(N) : job_s_len;
  assign w_zero_job   = (w_s_len == (LOG_N+1)'(0)) || (job_t_len == LEN_W'(0));
  assign w_drain_load = LEN_W'(r_s_len) + LEN_W'(PIPE_LAT);
  assign w_drain_en   = (r_state == ST_DRAIN) && !busy;
  assign w_credit_ok  = (credits != 2'd0);
  assign new_seq      = r_new_seq;
  assign ack          = r_new_seq;

  // State register.
  always_ff @(posedge clk) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic plus the combinational handshake readies.
  always_comb begin
    w_next_state = r_state;
    job_ready    = 1'b0;
    src_s_ready  = 1'b0;
    src_t_ready  = 1'b0;
    w_accept     = 1'b0;
    w_s_beat     = 1'b0;
    w_t_beat     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        job_ready = w_credit_ok;
        if (job_valid && w_credit_ok) begin
          w_accept     = 1'b1;
          w_next_state = w_zero_job ? ST_DONE : ST_LOAD_S;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD_S: begin
        src_s_ready = 1'b1;
        if (src_s_valid) begin
          w_s_beat     = 1'b1;
          w_next_state = (r_s_cnt == (LOG_N+1)'(1)) ? ST_STREAM_T : ST_LOAD_S;
        end else begin
          w_next_state = ST_LOAD_S;
        end
      end
      ST_STREAM_T: begin
        src_t_ready = !busy;
        if (src_t_valid && !busy) begin
          w_t_beat     = 1'b1;
          w_next_state = (r_t_cnt == LEN_W'(1)) ? ST_DRAIN : ST_STREAM_T;
        end else begin
          w_next_state = ST_STREAM_T;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == LEN_W'(0)) w_next_state = ST_DONE;
        else                          w_next_state = ST_DRAIN;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Job counters and the registered DP-facing strobes and data.
  // new_seq is raised on the last drain decrement so it coincides with a
  // drain count of zero; done follows one cycle after the DONE state.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_s_len     <= (LOG_N+1)'(0);
      r_s_cnt     <= (LOG_N+1)'(0);
      r_t_cnt     <= LEN_W'(0);
      r_drain_cnt <= LEN_W'(0);
      r_new_seq   <= 1'b0;
      S           <= BP_W'(0);
      T           <= BP_W'(0);
      s_update    <= 1'b0;
      valid       <= 1'b0;
      done        <= 1'b0;
      PE_end      <= LOG_N'(0);
    end else begin
      s_update  <= w_s_beat;
      valid     <= w_t_beat;
      done      <= (r_state == ST_DONE);
      r_new_seq <= w_drain_en && (r_drain_cnt == LEN_W'(1));
      if (w_accept) begin
        r_s_len <= w_s_len;
        r_s_cnt <= w_s_len;
        r_t_cnt <= job_t_len;
        if (!w_zero_job) PE_end <= w_s_len[LOG_N-1:0] - LOG_N'(1);
        else             PE_end <= PE_end;
      end else if (w_s_beat) begin
        S       <= src_s_data;
        r_s_cnt <= r_s_cnt - (LOG_N+1)'(1);
      end else if (w_t_beat) begin
        T       <= src_t_data;
        r_t_cnt <= r_t_cnt - LEN_W'(1);
        if (r_t_cnt == LEN_W'(1)) r_drain_cnt <= w_drain_load;
        else                      r_drain_cnt <= r_drain_cnt;
      end else if (w_drain_en && (r_drain_cnt != LEN_W'(0))) begin
        r_drain_cnt <= r_drain_cnt - LEN_W'(1);
      end else begin
        r_drain_cnt <= r_drain_cnt;
      end
    end
  end

  dp_bank_credit u_bank_credit (
    .clk       (clk),
    .reset_i   (reset_i),
    .i_consume (r_new_seq),
    .i_tb_busy (tb_busy),
    .o_credits (credits)
  );

`ifdef DP_SCHED_PERF_EN
  logic [15:0] r_perf_jobs;
  logic [15:0] r_perf_stalls;

  // Wrap-around job and stall counters.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_perf_jobs   <= 16'd0;
      r_perf_stalls <= 16'd0;
    end else begin
      if (done) r_perf_jobs <= r_perf_jobs + 16'd1;
      else      r_perf_jobs <= r_perf_jobs;
      if (is_dp_active(r_state) && busy) r_perf_stalls <= r_perf_stalls + 16'd1;
      else                               r_perf_stalls <= r_perf_stalls;
    end
  end

  assign perf_jobs   = r_perf_jobs;
  assign perf_stalls = r_perf_stalls;
`else
  assign perf_jobs   = 16'd0;
  assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_dp_sched.sv
// tb_dp_sched: directed self-checking bench for dp_sched (PIPE_LAT = 4).
module tb_dp_sched;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [6:0]  job_s_len = 7'd0;
  logic [11:0] job_t_len = 12'd0;
  logic        src_s_valid = 1'b0;
  logic [1:0]  src_s_data = 2'd0;
  logic        src_s_ready;
  logic        src_t_valid = 1'b0;
  logic [1:0]  src_t_data = 2'd0;
  logic        src_t_ready;
  logic [1:0]  S, T;
  logic        s_update, valid, new_seq, ack;
  logic [5:0]  PE_end;
  logic        busy = 1'b0;
  logic        tb_busy = 1'b0;
  logic        done;
  logic [1:0]  credits;
  logic [15:0] perf_jobs, perf_stalls;

  dp_sched dut (
    .clk(clk), .reset_i(reset_i), .job_valid(job_valid), .job_ready(job_ready),
    .job_s_len(job_s_len), .job_t_len(job_t_len),
    .src_s_valid(src_s_valid), .src_s_data(src_s_data), .src_s_ready(src_s_ready),
    .src_t_valid(src_t_valid), .src_t_data(src_t_data), .src_t_ready(src_t_ready),
    .S(S), .T(T), .s_update(s_update), .valid(valid), .new_seq(new_seq), .ack(ack),
    .PE_end(PE_end), .busy(busy), .tb_busy(tb_busy), .done(done), .credits(credits),
    .perf_jobs(perf_jobs), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int su_cnt = 0, v_cnt = 0, ns_cnt = 0, done_cnt = 0, ack_mis = 0;
  int last_v_cyc = 0, ns_cyc = 0, done_cyc = 0;
  logic [1:0] s_seen [0:255];
  logic [1:0] t_seen [0:255];
  int s_idx = 0, t_idx = 0;
  int job_a, snap_su, snap_v, snap_ns, snap_done, snap_sidx, snap_tidx;
  int exp_stalls, exp_jobs_t2, exp_jobs_end;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / data monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (s_update === 1'b1) begin s_seen[su_cnt & 255] <= S; su_cnt <= su_cnt + 1; end
    if (valid === 1'b1) begin t_seen[v_cnt & 255] <= T; v_cnt <= v_cnt + 1; last_v_cyc <= cyc; end
    if (new_seq === 1'b1) begin ns_cnt <= ns_cnt + 1; ns_cyc <= cyc; end
    if (done === 1'b1) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (ack !== new_seq) ack_mis <= ack_mis + 1;
  end

  function automatic logic [1:0] pat_s(input int i);
    int v;
    v = i + 3;
    return v[1:0];
  endfunction

  function automatic logic [1:0] pat_t(input int i);
    int v;
    v = i ^ (i >> 1);
    return v[1:0];
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: note accepted source beats, advance to just after the next edge.
  task automatic step();
    #1;
    if (src_s_valid && src_s_ready) s_idx++;
    if (src_t_valid && src_t_ready) t_idx++;
    @(posedge clk);
    #1;
    src_s_data = pat_s(s_idx);
    src_t_data = pat_t(t_idx);
  endtask

  task automatic start_job(input int s, input int t);
    job_s_len = 7'(s);
    job_t_len = 12'(t);
    job_valid = 1'b1;
    job_a     = cyc;
    snap_su   = su_cnt;  snap_v = v_cnt;  snap_ns = ns_cnt;  snap_done = done_cnt;
    snap_sidx = s_idx;   snap_tidx = t_idx;
  endtask

  task automatic finish_job(input int es, input int et, input int ens, input int lat);
    int k;
    k = 0;
    while ((done_cnt == snap_done) && (k < 300)) begin step(); k++; end
    chk("done_seen", int'(done_cnt > snap_done), 1);
    chk("s_update_pulses", su_cnt - snap_su, es);
    chk("valid_pulses", v_cnt - snap_v, et);
    chk("new_seq_pulses", ns_cnt - snap_ns, ens);
    chk("done_latency", done_cyc - job_a, lat);
    for (int i = 0; i < es; i++) chk("S_data", int'(s_seen[(snap_su + i) & 255]), int'(pat_s(snap_sidx + i)));
    for (int i = 0; i < et; i++) chk("T_data", int'(t_seen[(snap_v + i) & 255]), int'(pat_t(snap_tidx + i)));
  endtask

  task automatic return_credit();
    tb_busy = 1'b1; step();
    tb_busy = 1'b0; step();
  endtask

  initial begin
`ifdef DP_SCHED_PERF_EN
    exp_stalls = 5;  exp_jobs_t2 = 2;  exp_jobs_end = 1;
`else
    exp_stalls = 0;  exp_jobs_t2 = 0;  exp_jobs_end = 0;
`endif
    // Reset state
    step(); step();
    reset_i = 1'b0;
    chk("rst_credits", int'(credits), 2);
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_S_T", int'({S, T}), 0);
    chk("rst_strobes", int'({s_update, valid, new_seq, ack, done}), 0);
    chk("rst_PE_end", int'(PE_end), 0);
    chk("rst_src_ready", int'({src_s_ready, src_t_ready}), 0);
    chk("rst_perf", int'({perf_jobs, perf_stalls}), 0);
    src_s_valid = 1'b1;
    src_t_valid = 1'b1;
    step();

    // Single job: s=4, t=8
    start_job(4, 8); step(); job_valid = 1'b0;
    finish_job(4, 8, 1, 23);
    chk("t1_new_seq_after_last_T", ns_cyc - last_v_cyc, 8);
    chk("t1_PE_end", int'(PE_end), 3);
    chk("t1_credits", int'(credits), 1);
    return_credit();
    chk("t1_credit_return", int'(credits), 2);

    // Back-pressure: busy high for 5 cycles after two reference beats
    start_job(2, 8); step(); job_valid = 1'b0;
    step(); step(); step(); step();
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin #1; chk("t2_ready_low", int'(src_t_ready), 0); step(); end
    busy = 1'b0;
    #1; chk("t2_ready_back", int'(src_t_ready), 1);
    finish_job(2, 8, 1, 24);
    chk("t2_perf_stalls", int'(perf_stalls), exp_stalls);
    chk("t2_perf_jobs", int'(perf_jobs), exp_jobs_t2);
    return_credit();
    chk("t2_credits", int'(credits), 2);

    // Credit exhaustion with tb_busy held high
    tb_busy = 1'b1;
    start_job(1, 1); step(); job_valid = 1'b0;
    finish_job(1, 1, 1, 10);
    chk("t3_credits_1", int'(credits), 1);
    start_job(1, 1); step(); job_valid = 1'b0;
    finish_job(1, 1, 1, 10);
    chk("t3_credits_0", int'(credits), 0);
    start_job(1, 2);
    chk("t3_job_ready_low", int'(job_ready), 0);
    step();
    chk("t3_not_accepted", int'({job_ready, src_s_ready}), 0);
    tb_busy = 1'b0;
    step();
    chk("t3_credit_back", int'(credits), 1);
    chk("t3_job_ready_high", int'(job_ready), 1);
    job_a = cyc;
    step();
    chk("t3_accepted", int'({src_s_ready, job_ready}), 2);
    job_valid = 1'b0;
    finish_job(1, 2, 1, 11);
    chk("t3_credits_end", int'(credits), 0);

    // Simultaneous release and consume at credits = 1
    return_credit();
    chk("t4_credits_pre", int'(credits), 1);
    tb_busy = 1'b1; step();
    start_job(2, 1); step(); job_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    tb_busy = 1'b0;
    chk("t4_new_seq_now", int'(new_seq), 1);
    step();
    chk("t4_credits_hold", int'(credits), 1);
    finish_job(2, 1, 1, 12);
    chk("t4_PE_end", int'(PE_end), 1);

    // Zero-length jobs
    start_job(3, 0); step(); job_valid = 1'b0;
    finish_job(0, 0, 0, 2);
    chk("t5a_credits", int'(credits), 1);
    chk("t5a_PE_end", int'(PE_end), 1);
    start_job(0, 5); step(); job_valid = 1'b0;
    finish_job(0, 0, 0, 2);
    chk("t5b_credits", int'(credits), 1);

    // Reset during STREAM_T
    start_job(2, 6); step(); job_valid = 1'b0;
    step(); step(); step();
    reset_i = 1'b1; step(); reset_i = 1'b0;
    chk("t6_credits", int'(credits), 2);
    chk("t6_job_ready", int'(job_ready), 1);
    chk("t6_S_T", int'({S, T}), 0);
    chk("t6_strobes", int'({s_update, valid, new_seq, ack, done}), 0);
    chk("t6_PE_end", int'(PE_end), 0);
    snap_ns = ns_cnt; snap_done = done_cnt;
    for (int i = 0; i < 20; i++) step();
    chk("t6_no_new_seq", ns_cnt - snap_ns, 0);
    chk("t6_no_done", done_cnt - snap_done, 0);
    start_job(4, 8); step(); job_valid = 1'b0;
    finish_job(4, 8, 1, 23);
    chk("t6_PE_end_after", int'(PE_end), 3);
    chk("t6_credits_after", int'(credits), 1);
    chk("t6_perf_jobs", int'(perf_jobs), exp_jobs_end);
    chk("t6_perf_stalls", int'(perf_stalls), 0);

    chk("ack_matches_new_seq", ack_mis, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
